// File: rtl/debounce_multi_if.sv
// Button-side bundle for debounce_multi: raw levels in, debounced levels, edge pulses and tick out.
interface debounce_multi_if #(
    parameter int unsigned N_CH = 4
);
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] key;
    logic [N_CH-1:0] key_rise;
    logic [N_CH-1:0] key_fall;
    logic [N_CH-1:0] long_press;
    logic            tick;

    modport master (
        output btn_in,
        input  key, key_rise, key_fall, long_press, tick
    );

    modport slave (
        input  btn_in,
        output key, key_rise, key_fall, long_press, tick
    );
endinterface

// File: rtl/debounce_multi.sv
// N-channel tick-sampled button debouncer with press/release pulses.
// Optional long-press detector enabled by defining DEBOUNCE_LONG_PRESS_EN.
module debounce_multi #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned STABLE_TICKS = 30,
    parameter int unsigned LONG_TICKS   = 1000
) (
    input  logic             clk,
    input  logic             rst,
    debounce_multi_if.slave  bus
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);

    if (N_CH < 1 || CLK_DIV < 2 || STABLE_TICKS < 2 || LONG_TICKS < 1) begin : g_bad_param
        $error("debounce_multi: parameter out of range");
    end

    logic [DIV_W-1:0]            div_cnt_q, div_cnt_d;
    logic                        tick_q, tick_d;
    logic [N_CH-1:0]             s0_q, s0_d, s1_q, s1_d;
    logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]             key_q, key_d;
    logic [N_CH-1:0]             rise_q, rise_d, fall_q, fall_d;

    // Shared sample strobe: one clk high after div_cnt reaches CLK_DIV-1
    always_comb begin
        tick_d    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        div_cnt_d = tick_d ? '0 : div_cnt_q + DIV_W'(1);
    end

    // Per-channel sampling, stability count and acceptance, only on tick cycles
    always_comb begin
        s0_d   = s0_q;
        s1_d   = s1_q;
        cnt_d  = cnt_q;
        key_d  = key_q;
        rise_d = '0;
        fall_d = '0;
        if (tick_q) begin
            s0_d = bus.btn_in;
            s1_d = s0_q;
            for (int i = 0; i < int'(N_CH); i++) begin
                if (s0_q[i] != s1_q[i]) begin
                    cnt_d[i] = '0;
                end else begin
                    if (cnt_q[i] < CNT_W'(STABLE_TICKS)) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                    if (cnt_q[i] == CNT_W'(STABLE_TICKS - 1) && s1_q[i] != key_q[i]) begin
                        key_d[i]  = s1_q[i];
                        rise_d[i] = s1_q[i];
                        fall_d[i] = ~s1_q[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            s0_q      <= '0;
            s1_q      <= '0;
            cnt_q     <= '0;
            key_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign bus.tick     = tick_q;
    assign bus.key      = key_q;
    assign bus.key_rise = rise_q;
    assign bus.key_fall = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);

    logic [N_CH-1:0][HOLD_W-1:0] hold_q, hold_d;
    logic [N_CH-1:0]             lp_q, lp_d;

    // Hold counter runs only while the debounced key is high; pulse once on reaching LONG_TICKS
    always_comb begin
        hold_d = hold_q;
        lp_d   = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (!key_q[i]) begin
                hold_d[i] = '0;
            end else if (tick_q && hold_q[i] < HOLD_W'(LONG_TICKS)) begin
                hold_d[i] = hold_q[i] + HOLD_W'(1);
                lp_d[i]   = (hold_q[i] == HOLD_W'(LONG_TICKS - 1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            lp_q   <= '0;
        end else begin
            hold_q <= hold_d;
            lp_q   <= lp_d;
        end
    end

    assign bus.long_press = lp_q;
`else
    assign bus.long_press = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi against a run-length reference model of the button rules.
module tb_debounce_multi;
    localparam int unsigned N       = 4;
    localparam int unsigned CLK_DIV = 50;
    localparam int unsigned STABLE  = 30;
    localparam int unsigned LONG    = 40;
`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    debounce_multi_if #(.N_CH(N)) bus ();

    debounce_multi #(
        .N_CH(N), .CLK_DIV(CLK_DIV), .STABLE_TICKS(STABLE), .LONG_TICKS(LONG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level is accepted once it has been seen on STABLE+1 consecutive ticks
    int       m_cyc;
    bit       m_tick;
    bit [3:0] m_key, m_rise, m_fall, m_lp;
    int       m_len  [4];
    bit       m_val  [4];
    int       m_held [4];

    always @(posedge clk or posedge rst) begin : model
        bit [3:0] nk, nr, nf, nl;
        int       nlen [4];
        bit       nval [4];
        int       nheld[4];
        if (rst) begin
            m_cyc <= 0; m_tick <= 1'b0;
            m_key <= '0; m_rise <= '0; m_fall <= '0; m_lp <= '0;
            for (int c = 0; c < 4; c++) begin
                m_len[c] <= 2; m_val[c] <= 1'b0; m_held[c] <= 0;
            end
        end else begin
            nk = m_key; nr = '0; nf = '0; nl = '0;
            nlen = m_len; nval = m_val; nheld = m_held;
            for (int c = 0; c < 4; c++) begin
                if (!m_key[c]) nheld[c] = 0;
                if (m_tick) begin
                    if (nlen[c] == int'(STABLE) + 1 && nval[c] != m_key[c]) begin
                        nk[c] = nval[c];
                        if (nval[c]) nr[c] = 1'b1; else nf[c] = 1'b1;
                    end
                    if (LP_EN && m_key[c] && nheld[c] < int'(LONG)) begin
                        nheld[c]++;
                        if (nheld[c] == int'(LONG)) nl[c] = 1'b1;
                    end
                    if (bus.btn_in[c] == nval[c]) begin
                        if (nlen[c] < int'(STABLE) + 2) nlen[c]++;
                    end else begin
                        nval[c] = bus.btn_in[c];
                        nlen[c] = 1;
                    end
                end
            end
            m_cyc  <= m_cyc + 1;
            m_tick <= ((m_cyc + 1) % int'(CLK_DIV) == 0);
            m_key <= nk; m_rise <= nr; m_fall <= nf; m_lp <= nl;
            m_len <= nlen; m_val <= nval; m_held <= nheld;
        end
    end

    logic [16:0] obs, expv;
    assign obs  = {bus.key, bus.key_rise, bus.key_fall, bus.long_press, bus.tick};
    assign expv = {m_key, m_rise, m_fall, m_lp, m_tick};

    task automatic test_reset();
        bit exp_t;
        rst = 1'b1;
        bus.btn_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 160; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL reset_state cyc=%0d got=%h exp=%h", c, obs, expv);
            end
            if (c == 49 || c == 50 || c == 100) begin
                exp_t = (c != 49);
                vectors++;
                if (bus.tick !== exp_t) begin
                    miscompares++;
                    $display("FAIL first_tick cyc=%0d got=%b exp=%b", c, bus.tick, exp_t);
                end
            end
        end
    endtask

    task automatic test_single_press();
        int rises = 0;
        for (int g = 0; g < int'(CLK_DIV) + 2 && !m_tick; g++) begin
            @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL single_wait got=%h exp=%h", obs, expv);
            end
        end
        @(negedge clk);
        bus.btn_in[0] = 1'b1;
        repeat (34 * CLK_DIV) begin
            @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL single_press cyc=%0d got=%h exp=%h", m_cyc, obs, expv);
            end
            if (bus.key_rise[0]) rises++;
        end
        vectors++;
        if (rises !== 1 || bus.key !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_rise_count got=%0d key=%b exp=1 key=0001", rises, bus.key);
        end
    endtask

    task automatic test_glitch();
        int ticks = 0, rises = 0, rise_tick = -1;
        bus.btn_in[1] = 1'b1;
        while (ticks < 15) begin
            @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL glitch_pre cyc=%0d got=%h exp=%h", m_cyc, obs, expv);
            end
            if (m_tick) ticks++;
            if (bus.key_rise[1]) rises++;
        end
        bus.btn_in[1] = 1'b0;
        repeat (60) begin
            @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL glitch_low cyc=%0d got=%h exp=%h", m_cyc, obs, expv);
            end
            if (bus.key_rise[1]) rises++;
        end
        vectors++;
        if (rises !== 0) begin
            miscompares++;
            $display("FAIL glitch_early_rise got=%0d exp=0", rises);
        end
        bus.btn_in[1] = 1'b1;
        ticks = 0;
        repeat (36 * CLK_DIV) begin
            @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL glitch_post cyc=%0d got=%h exp=%h", m_cyc, obs, expv);
            end
            if (bus.key_rise[1]) begin rises++; rise_tick = ticks; end
            if (m_tick) ticks++;
        end
        vectors++;
        if (rises !== 1 || rise_tick < int'(STABLE)) begin
            miscompares++;
            $display("FAIL glitch_requalify got rises=%0d at_tick=%0d exp rises=1 at_tick>=%0d",
                     rises, rise_tick, STABLE);
        end
    endtask

    task automatic test_long_press();
        int lps = 0, falls = 0, ticks_since = -1, lp_tick = -1;
        int exp_lps;
        bus.btn_in[2] = 1'b1;
        repeat ((STABLE + LONG + 20) * CLK_DIV) begin
            @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL long_hold cyc=%0d got=%h exp=%h", m_cyc, obs, expv);
            end
            if (bus.long_press[2]) begin lps++; lp_tick = ticks_since; end
            if (bus.key_rise[2]) ticks_since = 0;
            else if (m_tick && ticks_since >= 0) ticks_since++;
        end
        exp_lps = LP_EN ? 1 : 0;
        vectors++;
        if (lps !== exp_lps || (LP_EN && lp_tick !== int'(LONG))) begin
            miscompares++;
            $display("FAIL long_press_once got=%0d at_tick=%0d exp=%0d at_tick=%0d",
                     lps, lp_tick, exp_lps, LONG);
        end
        bus.btn_in[2] = 1'b0;
        repeat (34 * CLK_DIV) begin
            @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL long_release cyc=%0d got=%h exp=%h", m_cyc, obs, expv);
            end
            if (bus.key_fall[2]) falls++;
            if (bus.long_press[2]) lps++;
        end
        vectors++;
        if (falls !== 1 || lps !== exp_lps || bus.key[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL long_release_fall got falls=%0d lps=%0d exp falls=1 lps=%0d",
                     falls, lps, exp_lps);
        end
    endtask

    task automatic test_simultaneous();
        int r0 = -1, r3 = -1;
        bus.btn_in = '0;
        repeat (34 * CLK_DIV + $urandom_range(0, CLK_DIV - 1)) begin
            @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL simul_settle cyc=%0d got=%h exp=%h", m_cyc, obs, expv);
            end
        end
        bus.btn_in = 4'b1001;
        for (int c = 0; c < 34 * int'(CLK_DIV); c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL simul_press cyc=%0d got=%h exp=%h", m_cyc, obs, expv);
            end
            if (bus.key_rise[0]) r0 = c;
            if (bus.key_rise[3]) r3 = c;
        end
        vectors++;
        if (r0 < 0 || r0 !== r3) begin
            miscompares++;
            $display("FAIL simul_same_clk got rise0=%0d rise3=%0d exp equal and present", r0, r3);
        end
    endtask

    task automatic test_reset_mid_press();
        int ticks = 0, rises = 0;
        while (ticks < 10) begin
            @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL rstmid_pre cyc=%0d got=%h exp=%h", m_cyc, obs, expv);
            end
            if (m_tick) ticks++;
        end
        #(1 + $urandom_range(0, 2));
        rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 17'h0) begin
            miscompares++;
            $display("FAIL rstmid_async got=%h exp=00000", obs);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (34 * CLK_DIV) begin
            @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL rstmid_post cyc=%0d got=%h exp=%h", m_cyc, obs, expv);
            end
            if (bus.key_rise[0]) rises++;
        end
        vectors++;
        if (rises !== 1 || bus.key[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_requalify got rises=%0d key0=%b exp rises=1 key0=1", rises, bus.key[0]);
        end
    endtask

    task automatic test_random();
        int hold [4];
        for (int c = 0; c < 4; c++) hold[c] = $urandom_range(1, 400);
        repeat (20000) begin
            @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", m_cyc, obs, expv);
            end
            for (int c = 0; c < 4; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    bus.btn_in[c] = ~bus.btn_in[c];
                    hold[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 120)
                                                           : $urandom_range(1500, 4500);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.btn_in  = '0;
        test_reset();
        test_single_press();
        test_glitch();
        test_long_press();
        test_simultaneous();
        test_reset_mid_press();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
